// File: rtl/master_ctrl_pkg.sv
// master_ctrl_pkg
//   Shared definitions for the master FIFO control blocks (drain and fill).
//   Holds the FSM state encoding and the default systolic array dimensions.
//   No ports; imported with "import master_ctrl_pkg::*".
package master_ctrl_pkg;

  // Default systolic array geometry: rows equal weight FIFO depth,
  // columns equal the number of weight FIFOs.
  localparam int DEFAULT_SYS_ARR_ROWS = 16;
  localparam int DEFAULT_SYS_ARR_COLS = 16;

  // Control FSM states, encoding shared with the fill controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/master_drain_fifo_control.sv
// master_drain_fifo_control
//   Drains the filled weight FIFOs into the systolic array. A start request
//   pops every active column FIFO for SYS_ARR_ROWS cycles (shifting the
//   weights down the array), then pulses weight_write for one cycle so the
//   array latches them, then returns to idle.
//
// Optional feature macro: DRAIN_STALL_EN
//   When defined, a stall input is compiled in; stall=1 during SHIFT pauses
//   the drain (no pops, shift counter held).
//
// Ports
//   clk          input   rising-edge clock
//   reset        input   synchronous, active-high reset
//   start        input   request one drain (accepted only in IDLE)
//   num_col      input   active columns minus one, captured on accepted start
//   stall        input   pause drain (only with DRAIN_STALL_EN)
//   done         output  high while idle
//   fifo_en      output  per-column FIFO pop / shift enable
//   weight_write output  one-cycle pulse, array latches shifted weights
module master_drain_fifo_control
  import master_ctrl_pkg::*;
#(
  parameter int SYS_ARR_ROWS = DEFAULT_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEFAULT_SYS_ARR_COLS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(SYS_ARR_COLS)-1:0] num_col,
`ifdef DRAIN_STALL_EN
  input  logic                            stall,
`endif
  output logic                            done,
  output logic [SYS_ARR_COLS-1:0]         fifo_en,
  output logic                            weight_write
);

  localparam int NCW   = $clog2(SYS_ARR_COLS);
  localparam int CNT_W = $clog2(SYS_ARR_ROWS) + 1;

  localparam logic [SYS_ARR_COLS-1:0] ALL_COLS = '1;
  localparam logic [NCW-1:0]          MAX_COL  = NCW'(SYS_ARR_COLS - 1);
  localparam logic [CNT_W-1:0]        LAST_ROW = CNT_W'(SYS_ARR_ROWS - 1);

  ctrl_state_t              state;
  ctrl_state_t              next_state;
  logic [CNT_W-1:0]         shift_cnt;
  logic [NCW-1:0]           num_col_reg;
  logic                     stall_active;
  logic [SYS_ARR_COLS-1:0]  col_mask;

`ifdef DRAIN_STALL_EN
  assign stall_active = stall;
`else
  assign stall_active = 1'b0;
`endif

  // Low num_col_reg+1 bits set: one enable per active column.
  assign col_mask = ALL_COLS >> (MAX_COL - num_col_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Shift counter and captured column count. The counter is cleared as the
  // FSM enters SHIFT so every drain starts from zero; num_col is only
  // sampled on the accepting edge so later changes cannot alter the mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_cnt   <= '0;
      num_col_reg <= '0;
    end else if (state == IDLE && start) begin
      shift_cnt   <= '0;
      num_col_reg <= num_col;
    end else if (state == SHIFT && !stall_active) begin
      shift_cnt <= shift_cnt + 1'b1;
    end
  end

  // Next-state logic. SHIFT ends on the edge closing its last non-stalled
  // cycle; start outside IDLE is simply not looked at, so nothing queues.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (!stall_active && shift_cnt == LAST_ROW) next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode. fifo_en is gated by stall so a paused cycle pops nothing;
  // fifo_en and weight_write come from disjoint states and never overlap.
  always_comb begin
    done         = (state == IDLE);
    weight_write = (state == WRITE);
    fifo_en      = '0;
    if (state == SHIFT && !stall_active) begin
      fifo_en = col_mask;
    end
  end

endmodule

// File: tb/tb_master_drain_fifo_control.sv
// tb_master_drain_fifo_control
//   Self-checking bench for master_drain_fifo_control with default geometry
//   (16x16). A transaction-level reference model tracks how many pops remain
//   in the current drain and whether a write pulse is due; every cycle the
//   DUT outputs are compared against it. Directed scenarios are followed by
//   a randomized run. Stall scenarios compile in with DRAIN_STALL_EN.
module tb_master_drain_fifo_control;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       num_col;
  logic             stall;
  logic             done;
  logic [COLS-1:0]  fifo_en;
  logic             weight_write;

  int vectors;
  int miscompares;
  int en_cycles;
  int ww_cycles;

  // Reference model state: pops still owed in the current drain, whether
  // the latch pulse is due this cycle, and the column mask of the drain.
  int               pops_left;
  bit               write_due;
  logic [COLS-1:0]  drain_mask;

  master_drain_fifo_control #(
    .SYS_ARR_ROWS(ROWS),
    .SYS_ARR_COLS(COLS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_col      (num_col),
`ifdef DRAIN_STALL_EN
    .stall        (stall),
`endif
    .done         (done),
    .fifo_en      (fifo_en),
    .weight_write (weight_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare all outputs against the model for the current cycle.
  task automatic checkOutput();
    logic            exp_done;
    logic            exp_ww;
    logic [COLS-1:0] exp_en;
    exp_done = (pops_left == 0) && !write_due;
    exp_ww   = write_due;
    exp_en   = (pops_left > 0 && !stall) ? drain_mask : '0;
    vectors++;
    assert (done === exp_done) else begin
      miscompares++;
      $error("[TB] FAIL done at %0t: observed %b expected %b", $time, done, exp_done);
    end
    vectors++;
    assert (weight_write === exp_ww) else begin
      miscompares++;
      $error("[TB] FAIL weight_write at %0t: observed %b expected %b", $time, weight_write, exp_ww);
    end
    vectors++;
    assert (fifo_en === exp_en) else begin
      miscompares++;
      $error("[TB] FAIL fifo_en at %0t: observed %h expected %h", $time, fifo_en, exp_en);
    end
    if (fifo_en != '0) en_cycles++;
    if (weight_write) ww_cycles++;
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic updateModel();
    if (reset) begin
      pops_left = 0;
      write_due = 1'b0;
    end else if (write_due) begin
      write_due = 1'b0;
    end else if (pops_left > 0) begin
      if (!stall) begin
        pops_left--;
        if (pops_left == 0) write_due = 1'b1;
      end
    end else if (start) begin
      pops_left  = ROWS;
      drain_mask = COLS'((32'd1 << (int'(num_col) + 1)) - 1);
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, then cross the edge.
  task automatic applyStimulus(input logic s, input logic r,
                               input logic [3:0] n, input logic st);
    start   = s;
    reset   = r;
    num_col = n;
    stall   = st;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    en_cycles   = 0;
    ww_cycles   = 0;
    pops_left   = 0;
    write_due   = 1'b0;
    drain_mask  = '0;
    start       = 1'b0;
    reset       = 1'b1;
    num_col     = 4'd0;
    stall       = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then a full-width drain.
    $display("[TB] full-width drain");
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
    en_cycles = 0; ww_cycles = 0;
    applyStimulus(1'b1, 1'b0, 4'd15, 1'b0);
    for (int i = 0; i < ROWS + 4; i++) applyStimulus(1'b0, 1'b0, 4'd15, 1'b0);
    checkCount("full_drain_en_cycles", en_cycles, ROWS);
    checkCount("full_drain_ww_cycles", ww_cycles, 1);

    // Four-column drain with num_col changed mid-shift.
    $display("[TB] narrow drain, num_col changed mid-shift");
    en_cycles = 0; ww_cycles = 0;
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 4'd3, 1'b0);
    for (int i = 0; i < ROWS; i++) applyStimulus(1'b0, 1'b0, 4'd7, 1'b0);
    checkCount("narrow_drain_en_cycles", en_cycles, ROWS);

    // start held high: back-to-back drains.
    $display("[TB] start held high");
    en_cycles = 0; ww_cycles = 0;
    for (int i = 0; i < 3 * (ROWS + 2); i++) applyStimulus(1'b1, 1'b0, 4'd9, 1'b0);
    checkCount("back_to_back_en_cycles", en_cycles, 3 * ROWS);
    checkCount("back_to_back_ww_cycles", ww_cycles, 3);
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);

    // Reset in shift cycle 5 aborts the drain.
    $display("[TB] reset mid-shift");
    en_cycles = 0; ww_cycles = 0;
    applyStimulus(1'b1, 1'b0, 4'd15, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b0);
    for (int i = 0; i < ROWS + 2; i++) applyStimulus(1'b0, 1'b0, 4'd15, 1'b0);
    checkCount("abort_ww_cycles", ww_cycles, 0);

    // start pulsed during WRITE is ignored.
    $display("[TB] start during write");
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    for (int i = 0; i < ROWS; i++) applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    en_cycles = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'd1, 1'b0);
    checkCount("write_start_ignored_en", en_cycles, 0);

`ifdef DRAIN_STALL_EN
    // Three stalled cycles mid-shift, plus stall in IDLE and WRITE.
    $display("[TB] stall during shift");
    en_cycles = 0; ww_cycles = 0;
    applyStimulus(1'b1, 1'b0, 4'd15, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 4'd15, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'd15, 1'b1);
    for (int i = 0; i < ROWS - 6; i++) applyStimulus(1'b0, 1'b0, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd15, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd15, 1'b1);
    checkCount("stall_en_cycles", en_cycles, ROWS);
    checkCount("stall_ww_cycles", ww_cycles, 1);
`endif

    // Randomized run against the model.
    $display("[TB] random run");
    for (int i = 0; i < 600; i++) begin
      logic s, r, st;
      logic [3:0] n;
      s  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 59) == 0);
      n  = 4'($urandom_range(0, 15));
`ifdef DRAIN_STALL_EN
      st = ($urandom_range(0, 3) == 0);
`else
      st = 1'b0;
`endif
      applyStimulus(s, r, n, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
